mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a registered-read data memory.
// Each accepted request runs through IDLE -> ISSUE -> RESP; one transaction is in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a cycle where reqX_valid && reqX_ready; ready is
  // only ever high in IDLE, outside reset, and for the arbitration winner alone.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic              grant0, grant1;
  logic [DATA_W-1:0] rsp_data;

  // On contention the port that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign rsp_data = we_q ? '0 : mem_rdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = ISSUE;
          winner_d     = grant1;
          last_grant_d = grant1;
          we_d         = grant1 ? req1_we : req0_we;
          mem_addr_d   = grant1 ? req1_addr : req0_addr;
          mem_wdata_d  = grant1 ? req1_wdata : req0_wdata;
          mem_we_d     = we_d;
          mem_re_d     = !we_d;
        end
      end
      ISSUE: begin
        state_d      = RESP;
        rsp0_valid_d = !winner_q;
        rsp1_valid_d = winner_q;
      end
      RESP: begin
        state_d = IDLE;
        if (winner_q) hold1_d = rsp_data;
        else          hold0_d = rsp_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

  // Gating with reset kills an access whose ISSUE cycle coincides with reset.
  assign mem_we     = mem_we_q && !reset;
  assign mem_re     = mem_re_q && !reset;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_valid_q ? rsp_data : hold0_q;
  assign rsp1_rdata = rsp1_valid_q ? rsp_data : hold1_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic, all checked every
// cycle against a transaction-timed reference model with its own copy of memory contents.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset
  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // The physical memory the arbiter drives.
  logic [DW-1:0] phys [0:255];
  always @(posedge clock) begin
    if (mem_we) phys[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= phys[mem_addr];
  end

  // ---------------- scoreboard bookkeeping
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Observations of DUT events, used by the directed literal checks.
  logic [DW-1:0] rsp0_obs[$];
  logic [DW-1:0] rsp1_obs[$];
  int            acc_port[$];
  int            acc_cyc[$];
  int            we_cyc[$];

  task automatic clear_obs();
    rsp0_obs.delete(); rsp1_obs.delete();
    acc_port.delete(); acc_cyc.delete(); we_cyc.delete();
  endtask

  // ---------------- reference model
  // A transaction accepted in cycle n writes/reads memory in cycle n+1, responds in n+2,
  // and the arbiter may accept again from n+3 on.
  int            cyc = 0;
  int            next_free = 0;
  int            acc = 0;
  bit            pend = 1'b0;
  bit            last_g = 1'b1;
  bit            t_port, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [DW-1:0] hold [0:1];
  logic [DW-1:0] golden [0:255];
  logic [DW-1:0] exp_q[$];

  always @(negedge clock) begin
    bit e_r0, e_r1, issuing, responding;
    cyc++;
    if (reset) begin
      chk("ready0_in_reset", req0_ready, 0);
      chk("ready1_in_reset", req1_ready, 0);
      chk("mem_we_in_reset", mem_we, 0);
      chk("mem_re_in_reset", mem_re, 0);
      pend = 1'b0; next_free = cyc + 1; last_g = 1'b1;
      hold[0] = '0; hold[1] = '0;
      exp_q.delete();
    end else begin
      if (req0_valid && req0_ready) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (req1_valid && req1_ready) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (rsp0_valid) rsp0_obs.push_back(rsp0_rdata);
      if (rsp1_valid) rsp1_obs.push_back(rsp1_rdata);
      if (mem_we) we_cyc.push_back(cyc);

      e_r0 = 1'b0; e_r1 = 1'b0;
      if (cyc >= next_free) begin
        if (req0_valid && req1_valid) begin
          if (last_g) e_r0 = 1'b1; else e_r1 = 1'b1;
        end else begin
          e_r0 = req0_valid; e_r1 = req1_valid;
        end
      end
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);

      issuing    = pend && (cyc == acc + 1);
      responding = pend && (cyc == acc + 2);
      chk("mem_we", mem_we, issuing && t_we);
      chk("mem_re", mem_re, issuing && !t_we);
      if (issuing) begin
        chk("mem_addr", mem_addr, t_addr);
        if (t_we) begin
          chk("mem_wdata", mem_wdata, t_wdata);
          golden[t_addr] = t_wdata;
        end
        exp_q.push_back(t_we ? '0 : golden[t_addr]);
      end
      if (responding) begin
        hold[t_port] = exp_q.pop_front();
        pend = 1'b0;
      end
      chk("rsp0_valid", rsp0_valid, responding && !t_port);
      chk("rsp1_valid", rsp1_valid, responding && t_port);
      chk("rsp0_rdata", rsp0_rdata, hold[0]);
      chk("rsp1_rdata", rsp1_rdata, hold[1]);

      if (e_r0 || e_r1) begin
        pend = 1'b1; acc = cyc; t_port = e_r1; last_g = e_r1; next_free = cyc + 3;
        t_we    = e_r1 ? req1_we : req0_we;
        t_addr  = e_r1 ? req1_addr : req0_addr;
        t_wdata = e_r1 ? req1_wdata : req0_wdata;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1)
  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int budget, input bit must, output bit ok);
    ok = 1'b0;
    set_req(p, 1'b1, we, a, d);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if ((p == 0) ? req0_ready : req1_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    if (must) chk($sformatf("accept_timeout_p%0d", p), ok, 1);
  endtask

  task automatic go(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    issue(p, we, a, d, 20, 1'b1, ok);
  endtask

  task automatic rand_port(input int p, input int n);
    bit            ok;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      if ($urandom_range(0, 7) == 0) issue(p, we, a, d, 1, 1'b0, ok);
      else                           issue(p, we, a, d, 20, 1'b1, ok);
    end
  endtask

  // ---------------- directed + random stimulus
  initial begin
    for (int i = 0; i < 256; i++) begin
      phys[i] = '0;
      golden[i] = '0;
    end
    hold[0] = '0; hold[1] = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_rsp0_rdata", rsp0_rdata, 0);
    chk("reset_rsp1_rdata", rsp1_rdata, 0);
    @(posedge clock); #1;

    // Write then read back on port 0; write response carries zero data.
    clear_obs();
    go(0, 1'b1, 8'h10, 8'hA5);
    go(0, 1'b1, 8'h12, 8'h3C);
    go(0, 1'b0, 8'h10, 8'h00);
    idle(3);
    chk("t1_rsp0_count", rsp0_obs.size(), 3);
    chk("t1_rsp1_count", rsp1_obs.size(), 0);
    if (rsp0_obs.size() == 3) begin
      chk("t1_write_rsp_zero", rsp0_obs[0], 8'h00);
      chk("t1_read_data", rsp0_obs[2], 8'hA5);
    end
    if (we_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t1_we_one_after_accept", we_cyc[0] - acc_cyc[0], 1);
    else chk("t1_we_seen", we_cyc.size(), 1);
    if (acc_cyc.size() == 3) chk("t1_accept_spacing", acc_cyc[1] - acc_cyc[0], 3);

    // Fresh reset, then both ports read continuously: grants alternate 0,1,0,1.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_obs();
    fork
      begin go(0, 1'b0, 8'h10, 8'h00); go(0, 1'b0, 8'h10, 8'h00); end
      begin go(1, 1'b0, 8'h12, 8'h00); go(1, 1'b0, 8'h12, 8'h00); end
    join
    idle(3);
    chk("t2_accepts", acc_port.size(), 4);
    if (acc_port.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), acc_port[i], i % 2);
      for (int i = 1; i < 4; i++) chk($sformatf("t2_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
    end
    chk("t2_rsp0_count", rsp0_obs.size(), 2);
    chk("t2_rsp1_count", rsp1_obs.size(), 2);
    foreach (rsp0_obs[i]) chk("t2_rsp0_data", rsp0_obs[i], 8'hA5);
    foreach (rsp1_obs[i]) chk("t2_rsp1_data", rsp1_obs[i], 8'h3C);

    // Port 1 writes at the address extremes; port 0 reads them back.
    clear_obs();
    go(1, 1'b1, 8'h00, 8'h11);
    go(1, 1'b1, 8'h01, 8'h22);
    go(1, 1'b1, 8'hFE, 8'h33);
    go(1, 1'b1, 8'hFF, 8'h44);
    go(0, 1'b0, 8'hFF, 8'h00);
    go(0, 1'b0, 8'h00, 8'h00);
    go(0, 1'b0, 8'h01, 8'h00);
    go(0, 1'b0, 8'hFE, 8'h00);
    idle(3);
    exp_q.push_back(8'h44); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    chk("t3_rsp0_count", rsp0_obs.size(), 4);
    for (int i = 0; i < 4 && i < rsp0_obs.size(); i++)
      chk($sformatf("t3_readback%0d", i), rsp0_obs[i], exp_q[exp_q.size() - 4 + i]);
    repeat (4) void'(exp_q.pop_back());
    chk("t3_write_rsp1_count", rsp1_obs.size(), 4);

    // Port 0 raised during the ISSUE cycle of a port 1 read waits for the next IDLE.
    clear_obs();
    go(1, 1'b0, 8'hFE, 8'h00);
    go(0, 1'b0, 8'h01, 8'h00);
    idle(3);
    if (acc_cyc.size() == 2) chk("t4_wait_cycles", acc_cyc[1] - acc_cyc[0], 3);
    else chk("t4_accepts", acc_cyc.size(), 2);
    if (rsp1_obs.size() == 1) chk("t4_rsp1_data", rsp1_obs[0], 8'h33);
    else chk("t4_rsp1_count", rsp1_obs.size(), 1);
    if (rsp0_obs.size() == 1) chk("t4_rsp0_data", rsp0_obs[0], 8'h22);
    else chk("t4_rsp0_count", rsp0_obs.size(), 1);

    // Reset lands on the ISSUE cycle of a write: the write never happens.
    clear_obs();
    go(0, 1'b1, 8'h20, 8'h77);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_we_blocked", mem_we, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
    chk("t5_no_rsp0", rsp0_obs.size(), 0);
    clear_obs();
    fork
      go(0, 1'b1, 8'h30, 8'h01);
      go(1, 1'b1, 8'h31, 8'h02);
    join
    idle(3);
    if (acc_port.size() == 2) chk("t5_port0_first", acc_port[0], 0);
    else chk("t5_accepts", acc_port.size(), 2);
    clear_obs();
    go(0, 1'b0, 8'h20, 8'h00);
    idle(3);
    if (rsp0_obs.size() == 1) chk("t5_loc_unwritten", rsp0_obs[0], 8'h00);
    else chk("t5_read_count", rsp0_obs.size(), 1);

    // Random concurrent traffic on both ports, including abandoned requests.
    clear_obs();
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    idle(5);
    chk("rand_rsp_per_accept", rsp0_obs.size() + rsp1_obs.size(), acc_port.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
